boot_loader_ctrl: RTL

Hardware boot sequencer for the RV32 SoC. It holds the core in reset, programs the UART divisor and line format, and receives a program image byte-by-byte over the UART. It packs the bytes little-endian into instruction memory, then releases the core. It sits between the UART bus slave, the instruction-memory write port and the core reset input, and replaces the software bootloader loop.

---
 rtl/boot_loader_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - UART image boot sequencer that loads instruction memory and releases the core
module boot_loader_ctrl #(
    parameter logic [31:0] UART_BASE  = 32'h2000_0000,
    parameter int          IMEM_BYTES = 256,
    parameter logic [15:0] DIVISOR    = 16'h0146,
    parameter logic [7:0]  LCR_DLAB   = 8'h9B,
    parameter logic [7:0]  LCR_RUN    = 8'h1B,
    // Word index width; a single-word image still gets a 1-bit address port.
    localparam int         AW         = (IMEM_BYTES > 4) ? $clog2(IMEM_BYTES / 4) : 1,
    // One spare bit so the byte counter can represent IMEM_BYTES itself.
    localparam int         CW         = $clog2(IMEM_BYTES) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          boot_en,
    output logic          bus_req,
    output logic          bus_we,
    output logic [31:0]   bus_addr,
    output logic [31:0]   bus_wdata,
    input  logic          bus_ack,
    input  logic [31:0]   bus_rdata,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_reset,
    output logic          boot_done
);

    // UART register byte offsets
    localparam logic [31:0] OFF_DATA = 32'd0;  // RBR / THR / DLL
    localparam logic [31:0] OFF_DLM  = 32'd1;
    localparam logic [31:0] OFF_LCR  = 32'd3;
    localparam logic [31:0] OFF_LSR  = 32'd5;

    typedef enum logic [3:0] {
        IDLE,
        CFG_LCR_DLAB,
        CFG_DLM,
        CFG_DLL,
        CFG_LCR_RUN,
        POLL_LSR,
        READ_RBR,
        ECHO,
        WRITE_WORD,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   byte_cnt;
    logic [31:0]     word_buf;
    logic [7:0]      rx_byte;

    // Only the low byte of a read carries data (LSR or RBR)
    logic [23:0] unused_rdata;
    assign unused_rdata = bus_rdata[31:8];

    // Sequencer: every output is registered here. A bus state first raises
    // bus_req (when it is low) and holds the request fields until the ack
    // edge, where it drops bus_req and moves on. That leaves one idle cycle
    // between consecutive transactions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
            boot_done  <= 1'b0;
            byte_cnt   <= '0;
            word_buf   <= 32'd0;
            rx_byte    <= 8'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (boot_en) begin
                        state <= CFG_LCR_DLAB;
                    end else begin
                        state      <= DONE;
                        core_reset <= 1'b0;
                        boot_done  <= 1'b1;
                    end
                end

                CFG_LCR_DLAB: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= UART_BASE + OFF_LCR;
                        bus_wdata <= {24'd0, LCR_DLAB};
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= CFG_DLM;
                    end
                end

                CFG_DLM: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= UART_BASE + OFF_DLM;
                        bus_wdata <= {24'd0, DIVISOR[15:8]};
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= CFG_DLL;
                    end
                end

                CFG_DLL: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= UART_BASE + OFF_DATA;
                        bus_wdata <= {24'd0, DIVISOR[7:0]};
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= CFG_LCR_RUN;
                    end
                end

                CFG_LCR_RUN: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= UART_BASE + OFF_LCR;
                        bus_wdata <= {24'd0, LCR_RUN};
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= POLL_LSR;
                    end
                end

                // Spin on LSR.DR; a not-ready read simply gets re-issued
                POLL_LSR: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= UART_BASE + OFF_LSR;
                        bus_wdata <= 32'd0;
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_rdata[0]) begin
                            state <= READ_RBR;
                        end
                    end
                end

                READ_RBR: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= UART_BASE + OFF_DATA;
                        bus_wdata <= 32'd0;
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        word_buf[{byte_cnt[1:0], 3'b000} +: 8] <= bus_rdata[7:0];
                        rx_byte <= bus_rdata[7:0];
                        state   <= ECHO;
                    end
                end

                // Echo the byte back; on the last lane, stage the word write
                // so imem_we is high during the single WRITE_WORD cycle.
                ECHO: begin
                    if (!bus_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= UART_BASE + OFF_DATA;
                        bus_wdata <= {24'd0, rx_byte};
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (byte_cnt[1:0] == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= byte_cnt[AW+1:2];
                            imem_wdata <= word_buf;
                            state      <= WRITE_WORD;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                            state    <= POLL_LSR;
                        end
                    end
                end

                WRITE_WORD: begin
                    byte_cnt <= byte_cnt + CW'(1);
                    if (byte_cnt == CW'(IMEM_BYTES - 1)) begin
                        state      <= DONE;
                        core_reset <= 1'b0;
                        boot_done  <= 1'b1;
                    end else begin
                        state <= POLL_LSR;
                    end
                end

                // Terminal until reset; boot_en no longer matters
                DONE: begin
                    bus_req    <= 1'b0;
                    core_reset <= 1'b0;
                    boot_done  <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
